csr_m: RTL
==========

# csr_m

Machine/user-mode CSR file, next generation of the core's CSR block. It holds the trap state: mstatus, mie, mip, mtvec, mepc, mcause, mtval and mscratch. It also holds 64-bit mcycle/minstret counters and the current privilege level, and arbitrates a parametrised set of local interrupt lines. It sits beside the execute stage: the pipeline issues CSR ops and trap/mret events, and reads back rdata, trap vector, return address and the pending interrupt.

## Interface
- NUM_LOCAL, 4: local interrupt lines, 0..16, mapped to mip/mie bits 16+i.
- RESET_MTVEC, 32'h0000_0200: reset value of mtvec; bits [1:0] must be 0.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- csr_addr  in  12  CSR address.
- csr_op  in  2  00 none, 01 write, 10 set, 11 clear.
- csr_wdata  in  32  write/set/clear operand.
- csr_rdata  out  32  combinational read of csr_addr (pre-update value).
- csr_illegal  out  1  access is illegal; the op is suppressed.
- trap_take  in  1  commit a trap this cycle.
- trap_cause  in  32  mcause value; bit 31 = interrupt.
- trap_pc  in  32  pc written to mepc.
- trap_val  in  32  value written to mtval.
- mret  in  1  commit an mret this cycle.
- retire  in  1  one instruction retired this cycle.
- mtip, msip, meip  in  1 each  timer, software and external interrupt levels.
- irq_local  in  NUM_LOCAL  local interrupt levels.
- irq_pending  out  1  an enabled interrupt is pending and globally enabled.
- irq_cause  out  32  mcause for the highest-priority pending interrupt.
- trap_vector  out  32  target pc for trap_cause.
- ret_addr  out  32  current mepc.
- priv  out  2  current privilege: 11 = M, 00 = U.

## Operation
- Address map:
  - mstatus 300, misa 301 (RO, 0x4000_0100), mie 304, mtvec 305, mcountinhibit 320.
  - mscratch 340, mepc 341, mcause 342, mtval 343, mip 344 (RO).
  - mcycle B00/B80, minstret B02/B82, cycle C00/C80 (RO alias), instret C02/C82 (RO alias).
- csr_illegal is asserted when csr_op != 0 and any of the following holds:
  - the address is unmapped;
  - csr_addr[9:8] > priv;
  - write/set/clear targets a read-only address, i.e. csr_addr[11:10] == 11, misa or mip. Set/clear with csr_wdata == 0 is not illegal.
- New value = wdata, old|wdata or old&~wdata, then WARL-masked:
  - mstatus: only MIE[3], MPIE[7] and MPP[12:11] are kept; an MPP write of 01/10 becomes 00.
  - mie: bits 3, 7, 11 and 16..16+NUM_LOCAL-1 are writable.
  - mtvec: mode 01 is kept only when vectored mode is compiled in; any other mode becomes 00.
  - mepc: bits [1:0] forced to 0.
  - mcountinhibit: only bits 0 (CY) and 2 (IR) are writable.
- mip is read-only = {irq_local, 4'b0, meip, 3'b0, mtip, 3'b0, msip, 3'b0}.
- Interrupt arbitration:
  - irq_pending = |(mip & mie) && (priv == U || mstatus.MIE).
  - Priority: MEI(11) > MSI(3) > MTI(7) > local lowest index first.
  - irq_cause = {1'b1, 26'b0, code}.
- Trap entry, trap_take:
  - mepc = trap_pc & ~3, mcause = trap_cause, mtval = trap_val.
  - MPIE = MIE, MIE = 0, MPP = priv, priv = 11.
- mret:
  - MIE = MPIE, MPIE = 1, priv = MPP, MPP = 00.
- Priority: rst > trap_take > mret > CSR op. A suppressed or illegal op changes nothing.
- Counters:
  - mcycle +1 every cycle unless mcountinhibit.CY.
  - minstret +1 on retire unless mcountinhibit.IR.
  - Both wrap from 2^64-1 to 0.
  - A CSR write to either half of a counter replaces the increment for that counter in that cycle; the unwritten half holds.
- trap_vector:
  - mtvec base ({mtvec[31:2], 2'b00}) for exceptions and direct mode.
  - base + 4*cause[4:0] for interrupts in vectored mode.

## Timing
- All state updates on posedge clk and are visible the next cycle; csr_rdata, csr_illegal, irq_* and trap_vector are combinational.
- Reset values:
  - mstatus 0x0000_1800, mtvec RESET_MTVEC, priv 11.
  - All other CSRs and both counters 0.
  - Asserting rst during any operation discards it.
- Read-modify-write of a counter returns the pre-increment value; the written value appears next cycle without that cycle's increment.

## Configuration
- CSR_VECTORED_EN defined: mtvec mode 01 is retained and interrupts vector to base + 4*cause.
- Not defined: mtvec[1:0] reads 00 and all traps go to the base.

## Structure
- Package csr_pkg: CSR address localparams, op encoding, interrupt/exception cause codes, mstatus bit positions, WARL masks.
- Sub-module csr_counter64 (64-bit counter with inhibit, increment enable and per-half write), instantiated for mcycle and minstret.

## Test plan
- After reset: rdata at 300 = 0x1800, 305 = 0x200, B00 counts 0,1,2 over successive reads; priv = 11.
- csr_op = 01 on 300 with 0xFFFF_FFFF -> reads 0x1888; set on 301 -> illegal, misa unchanged.
- mie = 0x888, MIE = 1, mtip = 1 and meip = 1 together -> irq_cause = 0x8000_000B; trap_take -> MIE = 0, MPIE = 1, mcause = 0x8000_000B.
- Vectored mode, mtvec written 0x1001 -> trap_vector for cause 0x8000_0007 = 0x101C; without the macro, mtvec reads 0x1000 and trap_vector = 0x1000.
- MPP = 00, mret -> priv = 00; a read of 300 is then illegal and a read of C00 is legal; then trap_take -> priv = 11, MPP = 00.
- mcycle written 0xFFFF_FFFF at B00 and B80 -> next cycle reads 0xFFFF_FFFF at both; the cycle after wraps to 0; trap_take and csr_op in the same cycle -> the op is ignored.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared definitions for the machine/user-mode CSR file: addresses, op encoding,
// privilege levels, interrupt cause codes, mstatus bit positions and WARL masks.
package csr_pkg;

    // CSR address map
    localparam logic [11:0] CsrMstatus       = 12'h300;
    localparam logic [11:0] CsrMisa          = 12'h301;
    localparam logic [11:0] CsrMie           = 12'h304;
    localparam logic [11:0] CsrMtvec         = 12'h305;
    localparam logic [11:0] CsrMcountinhibit = 12'h320;
    localparam logic [11:0] CsrMscratch      = 12'h340;
    localparam logic [11:0] CsrMepc          = 12'h341;
    localparam logic [11:0] CsrMcause        = 12'h342;
    localparam logic [11:0] CsrMtval         = 12'h343;
    localparam logic [11:0] CsrMip           = 12'h344;
    localparam logic [11:0] CsrMcycle        = 12'hB00;
    localparam logic [11:0] CsrMcycleh       = 12'hB80;
    localparam logic [11:0] CsrMinstret      = 12'hB02;
    localparam logic [11:0] CsrMinstreth     = 12'hB82;
    localparam logic [11:0] CsrCycle         = 12'hC00;
    localparam logic [11:0] CsrCycleh        = 12'hC80;
    localparam logic [11:0] CsrInstret       = 12'hC02;
    localparam logic [11:0] CsrInstreth      = 12'hC82;

    typedef enum logic [1:0] {
        OpNone  = 2'b00,
        OpWrite = 2'b01,
        OpSet   = 2'b10,
        OpClear = 2'b11
    } csr_op_e;

    localparam logic [1:0] PrivU = 2'b00;
    localparam logic [1:0] PrivM = 2'b11;

    // Interrupt cause codes
    localparam logic [4:0]  IrqCodeMsi   = 5'd3;
    localparam logic [4:0]  IrqCodeMti   = 5'd7;
    localparam logic [4:0]  IrqCodeMei   = 5'd11;
    localparam int unsigned IrqLocalBase = 16;

    // mstatus bit positions
    localparam int unsigned MstatusMie   = 3;
    localparam int unsigned MstatusMpie  = 7;
    localparam int unsigned MstatusMppLo = 11;

    localparam logic [31:0] MisaValue  = 32'h4000_0100;
    localparam logic [31:0] MieStdMask = 32'h0000_0888;

    // Writable mie bits: standard MSI/MTI/MEI plus one bit per local line.
    function automatic logic [31:0] mie_mask(int unsigned num_local);
        logic [31:0] m;
        m = MieStdMask;
        for (int unsigned i = 0; i < num_local; i++) begin
            m[IrqLocalBase + i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with inhibit, increment enable and per-half write.
// A write to either half takes precedence over that cycle's increment.
module csr_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inhibit_i,
    input  logic        inc_en_i,
    input  logic        wr_lo_i,
    input  logic        wr_hi_i,
    input  logic [31:0] wdata_i,
    output logic [63:0] count_o
);

    logic [63:0] count_q, count_d;

    // Next count: written half replaces the increment, unwritten half holds.
    always_comb begin
        count_d = count_q;
        if (wr_lo_i || wr_hi_i) begin
            if (wr_lo_i) count_d[31:0]  = wdata_i;
            if (wr_hi_i) count_d[63:32] = wdata_i;
        end else if (inc_en_i && !inhibit_i) begin
            count_d = count_q + 64'd1;
        end
    end

    // Counter register, synchronous reset to zero.
    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/csr_m.sv
// Machine/user-mode CSR file: trap state, 64-bit counters, privilege level and
// interrupt arbitration. Define CSR_VECTORED_EN to retain mtvec vectored mode
// (interrupts go to base + 4*cause); otherwise all traps go to the base.
module csr_m
    import csr_pkg::*;
#(
    parameter int unsigned NUM_LOCAL   = 4,
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0200
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [11:0]          csr_addr,
    input  logic [1:0]           csr_op,
    input  logic [31:0]          csr_wdata,
    output logic [31:0]          csr_rdata,
    output logic                 csr_illegal,
    input  logic                 trap_take,
    input  logic [31:0]          trap_cause,
    input  logic [31:0]          trap_pc,
    input  logic [31:0]          trap_val,
    input  logic                 mret,
    input  logic                 retire,
    input  logic                 mtip,
    input  logic                 msip,
    input  logic                 meip,
    input  logic [NUM_LOCAL-1:0] irq_local,
    output logic                 irq_pending,
    output logic [31:0]          irq_cause,
    output logic [31:0]          trap_vector,
    output logic [31:0]          ret_addr,
    output logic [1:0]           priv
);

    localparam logic [31:0] MieMask = mie_mask(NUM_LOCAL);

    logic        st_mie_q, st_mie_d, st_mpie_q, st_mpie_d;
    logic [1:0]  st_mpp_q, st_mpp_d, priv_q, priv_d;
    logic [31:0] mie_q, mie_d, mtvec_q, mtvec_d, mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
    logic        cy_inh_q, cy_inh_d, ir_inh_q, ir_inh_d;
    logic [63:0] mcycle, minstret;
    logic [31:0] mstatus_rd, mip_rd, pend, csr_new;
    logic [15:0] lcl;
    logic [4:0]  irq_code;
    logic [1:0]  mtvec_mode_new;
    logic        mapped, read_only, write_intent, csr_we;

    // Assemble read-only views of mstatus and mip.
    always_comb begin
        mstatus_rd = '0;
        mstatus_rd[MstatusMie]                  = st_mie_q;
        mstatus_rd[MstatusMpie]                 = st_mpie_q;
        mstatus_rd[MstatusMppLo+1:MstatusMppLo] = st_mpp_q;
        lcl = '0;
        for (int unsigned i = 0; i < NUM_LOCAL; i++) lcl[i] = irq_local[i];
        mip_rd = {lcl, 4'b0, meip, 3'b0, mtip, 3'b0, msip, 3'b0};
    end

    // Address decode and combinational read of the pre-update value.
    always_comb begin
        csr_rdata = '0;
        mapped    = 1'b1;
        case (csr_addr)
            CsrMstatus:                csr_rdata = mstatus_rd;
            CsrMisa:                   csr_rdata = MisaValue;
            CsrMie:                    csr_rdata = mie_q;
            CsrMtvec:                  csr_rdata = mtvec_q;
            CsrMcountinhibit:          csr_rdata = {29'b0, ir_inh_q, 1'b0, cy_inh_q};
            CsrMscratch:               csr_rdata = mscratch_q;
            CsrMepc:                   csr_rdata = mepc_q;
            CsrMcause:                 csr_rdata = mcause_q;
            CsrMtval:                  csr_rdata = mtval_q;
            CsrMip:                    csr_rdata = mip_rd;
            CsrMcycle, CsrCycle:       csr_rdata = mcycle[31:0];
            CsrMcycleh, CsrCycleh:     csr_rdata = mcycle[63:32];
            CsrMinstret, CsrInstret:   csr_rdata = minstret[31:0];
            CsrMinstreth, CsrInstreth: csr_rdata = minstret[63:32];
            default:                   mapped    = 1'b0;
        endcase
    end

    // Set/clear with a zero operand is a pure read: it neither faults on
    // read-only CSRs nor writes (so it does not disturb counter increments).
    assign read_only    = (csr_addr[11:10] == 2'b11) || (csr_addr == CsrMisa)
                          || (csr_addr == CsrMip);
    assign write_intent = (csr_op == OpWrite) || (csr_wdata != '0);
    assign csr_illegal  = (csr_op != OpNone)
                          && (!mapped || (csr_addr[9:8] > priv_q) || (read_only && write_intent));
    assign csr_we       = (csr_op != OpNone) && write_intent && !csr_illegal
                          && !trap_take && !mret;

    // Raw new value before per-register WARL masking.
    always_comb begin
        unique case (csr_op_e'(csr_op))
            OpWrite: csr_new = csr_wdata;
            OpSet:   csr_new = csr_rdata | csr_wdata;
            OpClear: csr_new = csr_rdata & ~csr_wdata;
            default: csr_new = csr_rdata;
        endcase
    end

`ifdef CSR_VECTORED_EN
    assign mtvec_mode_new = (csr_new[1:0] == 2'b01) ? 2'b01 : 2'b00;
`else
    assign mtvec_mode_new = 2'b00;
`endif

    // Next state: trap entry beats mret, which beats a CSR op.
    always_comb begin
        st_mie_d   = st_mie_q;
        st_mpie_d  = st_mpie_q;
        st_mpp_d   = st_mpp_q;
        priv_d     = priv_q;
        mie_d      = mie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        cy_inh_d   = cy_inh_q;
        ir_inh_d   = ir_inh_q;
        if (trap_take) begin
            mepc_d    = {trap_pc[31:2], 2'b00};
            mcause_d  = trap_cause;
            mtval_d   = trap_val;
            st_mpie_d = st_mie_q;
            st_mie_d  = 1'b0;
            st_mpp_d  = priv_q;
            priv_d    = PrivM;
        end else if (mret) begin
            st_mie_d  = st_mpie_q;
            st_mpie_d = 1'b1;
            priv_d    = st_mpp_q;
            st_mpp_d  = PrivU;
        end else if (csr_we) begin
            case (csr_addr)
                CsrMstatus: begin
                    st_mie_d  = csr_new[MstatusMie];
                    st_mpie_d = csr_new[MstatusMpie];
                    // Only M and U exist; any other MPP collapses to U.
                    st_mpp_d  = (csr_new[MstatusMppLo+1:MstatusMppLo] == PrivM) ? PrivM : PrivU;
                end
                CsrMie:      mie_d      = csr_new & MieMask;
                CsrMtvec:    mtvec_d    = {csr_new[31:2], mtvec_mode_new};
                CsrMcountinhibit: begin
                    cy_inh_d = csr_new[0];
                    ir_inh_d = csr_new[2];
                end
                CsrMscratch: mscratch_d = csr_new;
                CsrMepc:     mepc_d     = {csr_new[31:2], 2'b00};
                CsrMcause:   mcause_d   = csr_new;
                CsrMtval:    mtval_d    = csr_new;
                default: ;
            endcase
        end
    end

    // CSR state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_mie_q   <= 1'b0;
            st_mpie_q  <= 1'b0;
            st_mpp_q   <= PrivM;
            priv_q     <= PrivM;
            mie_q      <= '0;
            mtvec_q    <= RESET_MTVEC;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
            cy_inh_q   <= 1'b0;
            ir_inh_q   <= 1'b0;
        end else begin
            st_mie_q   <= st_mie_d;
            st_mpie_q  <= st_mpie_d;
            st_mpp_q   <= st_mpp_d;
            priv_q     <= priv_d;
            mie_q      <= mie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
            cy_inh_q   <= cy_inh_d;
            ir_inh_q   <= ir_inh_d;
        end
    end

    csr_counter64 u_mcycle (
        .clk       (clk),
        .rst       (rst),
        .inhibit_i (cy_inh_q),
        .inc_en_i  (1'b1),
        .wr_lo_i   (csr_we && (csr_addr == CsrMcycle)),
        .wr_hi_i   (csr_we && (csr_addr == CsrMcycleh)),
        .wdata_i   (csr_new),
        .count_o   (mcycle)
    );

    csr_counter64 u_minstret (
        .clk       (clk),
        .rst       (rst),
        .inhibit_i (ir_inh_q),
        .inc_en_i  (retire),
        .wr_lo_i   (csr_we && (csr_addr == CsrMinstret)),
        .wr_hi_i   (csr_we && (csr_addr == CsrMinstreth)),
        .wdata_i   (csr_new),
        .count_o   (minstret)
    );

    // Interrupt arbitration; later assignments carry higher priority.
    always_comb begin
        logic found;
        pend     = mip_rd & mie_q;
        irq_code = '0;
        found    = 1'b0;
        for (int unsigned i = 0; i < NUM_LOCAL; i++) begin
            if (!found && pend[IrqLocalBase + i]) begin
                irq_code = 5'(IrqLocalBase + i);
                found    = 1'b1;
            end
        end
        if (pend[IrqCodeMti]) irq_code = IrqCodeMti;
        if (pend[IrqCodeMsi]) irq_code = IrqCodeMsi;
        if (pend[IrqCodeMei]) irq_code = IrqCodeMei;
        irq_pending = (|pend) && ((priv_q == PrivU) || st_mie_q);
        irq_cause   = (|pend) ? {1'b1, 26'b0, irq_code} : '0;
    end

    // Trap target from mtvec.
    always_comb begin
        trap_vector = {mtvec_q[31:2], 2'b00};
`ifdef CSR_VECTORED_EN
        if (trap_cause[31] && (mtvec_q[1:0] == 2'b01)) begin
            trap_vector = {mtvec_q[31:2], 2'b00} + {25'b0, trap_cause[4:0], 2'b00};
        end
`endif
    end

    assign ret_addr = mepc_q;
    assign priv     = priv_q;

endmodule
